ship_placement_ctrl: RTL
========================

Name: ship_placement_ctrl

Overview:
- Player ship-placement stage, directly upstream of the game-control FSM.
- Runs while the FSM is in its set-ships state: moves a cursor over the 5x5 board using active-low buttons and places single-cell ships.
- Delivers the player ship matrix and the all_ships_set flag that moves the FSM on to the player turn.
- Contains its own synchronizers and debouncers, so raw board pins connect directly.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable synchronized samples required before a button level is accepted (minimum 1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse from the FSM on entering set-ships; clears and (re)starts placement
- num_ships  input  3  ships to place; 0 is treated as 1, values >5 are clamped to 5; latched on start
- btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_sel_n  input  1 each  raw buttons, 0 = pressed
- ship_grid  output  2 x [4:0][4:0] unpacked  player ship matrix: 2'b00 empty, 2'b01 ship; 2'b10 and 2'b11 are never driven
- cursor_row, cursor_col  output  3 each  cursor position, 0..4
- ships_placed  output  3  count of ships placed so far
- all_ships_set  output  1  level, high in DONE
- place_err  output  1  one-cycle pulse when select hits an occupied cell

Behaviour:
- Reset: all ship_grid cells 00, cursor (0,0), ships_placed 0, all_ships_set 0, place_err 0, state IDLE.
- Reset also initialises the debounced levels to 1 (released), synchronizers to 1 and counters to 0.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized value differs from the debounced level; clears when they agree.
  - The debounced level flips on the edge at which the count would reach DEBOUNCE_CYCLES.
  - A press event is a debounced 1->0 transition; releases produce no event.
- Latency: a pin sampled low at edge N and held low produces its action visible on the outputs after edge N+DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- States:
  - IDLE: buttons ignored; outputs hold. start -> PLACING.
  - PLACING: executes button events as listed below.
  - DONE: all_ships_set=1; grid, cursor and count frozen; buttons ignored. start -> PLACING (restart).
- start action, accepted in any state:
  - Takes effect at the next edge: grid cleared, cursor (0,0), ships_placed 0, all_ships_set 0.
  - Target = clamp(num_ships) is latched.
  - start in the same cycle as a button event: start wins and the event is discarded.
- One action per cycle in PLACING. Priority: sel > up > down > left > right; lower-priority events in the same cycle are discarded, not queued.
- Cursor moves wrap around:
  - up: row 0 -> 4, else row-1.
  - down: row 4 -> 0, else row+1.
  - left and right: same rule applied to col.
- sel on an empty cell:
  - Cell becomes 01 and ships_placed increments.
  - If the new count equals the target, the state becomes DONE at the same edge, so all_ships_set rises together with the last grid write.
- sel on an occupied cell: grid and count unchanged; place_err pulses high for exactly one cycle.
- ships_placed never exceeds the target; no writes occur outside PLACING.
- rst mid-placement: immediate return to reset values; a later start is required.
- Grid indexing: ship_grid[row][col], row 0 is the top row and col 0 is the left column.

Test Plan:
- DEBOUNCE_CYCLES=4. rst, start with num_ships=3, then sel at (0,0) -> ship_grid[0][0]=01 exactly 7 edges after the pin is first sampled low; ships_placed=1; all_ships_set=0.
- Cursor at (0,0): press up, then left -> cursor (4,4). Press down, then right -> (0,0). No grid change.
- sel at (0,0) twice -> second press gives a one-cycle place_err; ships_placed stays 1; grid unchanged.
- num_ships=2: place at (0,0) and (2,3) -> all_ships_set=1 on the same edge as grid[2][3]=01. Further sel/move presses are ignored.
- num_ships=0 -> one placement reaches DONE. num_ships=7 -> DONE after exactly 5 placements.
- Pin low pulse of 3 cycles -> no event. sel+right events in the same cycle -> placement only, cursor unchanged.
- rst asserted asynchronously mid-placement -> grid all 00 with no clock edge, cursor (0,0), all_ships_set 0. start during DONE -> grid cleared, state PLACING.

Source files
------------

// File: rtl/ship_placement_ctrl.sv
// Player ship-placement stage: conditions five raw active-low buttons, moves a
// wrapping cursor over the 5x5 board and places single-cell ships up to a target.
module ship_placement_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] num_ships,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_sel_n,
    output logic [1:0] ship_grid [0:4][0:4],
    output logic [2:0] cursor_row,
    output logic [2:0] cursor_col,
    output logic [2:0] ships_placed,
    output logic       all_ships_set,
    output logic       place_err
);

    typedef enum logic [1:0] {IDLE, PLACING, DONE} state_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    logic [4:0]       btn_raw;
    logic [4:0]       sync1, sync2, deb, deb_d, press;
    logic [4:0][15:0] cnt;

    state_t     state, state_n;
    logic [1:0] grid_n [0:4][0:4];
    logic [2:0] row_n, col_n, placed_n, target, target_n, clamp;
    logic       err_n;

    assign btn_raw = {btn_sel_n, btn_right_n, btn_left_n, btn_down_n, btn_up_n};

    // Synchronize, debounce and turn each debounced 1->0 edge into a registered one-cycle press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            press <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= DEBOUNCE_CYCLES - 16'd1) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign clamp = (num_ships == 3'd0) ? 3'd1 :
                   (num_ships > 3'd5)  ? 3'd5 : num_ships;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ship_grid    <= '{default: 2'b00};
            cursor_row   <= 3'd0;
            cursor_col   <= 3'd0;
            ships_placed <= 3'd0;
            target       <= 3'd1;
            place_err    <= 1'b0;
        end else begin
            state        <= state_n;
            ship_grid    <= grid_n;
            cursor_row   <= row_n;
            cursor_col   <= col_n;
            ships_placed <= placed_n;
            target       <= target_n;
            place_err    <= err_n;
        end
    end

    // start overrides everything; otherwise at most one press acts per cycle, by priority.
    always_comb begin
        state_n  = state;
        grid_n   = ship_grid;
        row_n    = cursor_row;
        col_n    = cursor_col;
        placed_n = ships_placed;
        target_n = target;
        err_n    = 1'b0;
        if (start) begin
            state_n  = PLACING;
            grid_n   = '{default: 2'b00};
            row_n    = 3'd0;
            col_n    = 3'd0;
            placed_n = 3'd0;
            target_n = clamp;
        end else if (state == PLACING) begin
            if (press[BTN_SEL]) begin
                if (ship_grid[cursor_row][cursor_col] == 2'b00) begin
                    grid_n[cursor_row][cursor_col] = 2'b01;
                    placed_n = ships_placed + 3'd1;
                    if (placed_n == target) begin
                        state_n = DONE;
                    end
                end else begin
                    err_n = 1'b1;
                end
            end else if (press[BTN_UP]) begin
                row_n = (cursor_row == 3'd0) ? 3'd4 : cursor_row - 3'd1;
            end else if (press[BTN_DOWN]) begin
                row_n = (cursor_row == 3'd4) ? 3'd0 : cursor_row + 3'd1;
            end else if (press[BTN_LEFT]) begin
                col_n = (cursor_col == 3'd0) ? 3'd4 : cursor_col - 3'd1;
            end else if (press[BTN_RIGHT]) begin
                col_n = (cursor_col == 3'd4) ? 3'd0 : cursor_col + 3'd1;
            end
        end
    end

    assign all_ships_set = (state == DONE);

endmodule
